// File: rtl/cacheline_adapter_if.sv
// Cacheline-side and burst-memory-side bundles for the line adapter.
// cacheline_ufp_if : 256-bit whole-line request port; the cache is master, the adapter is slave.
// cacheline_bmem_if: 64-bit burst memory port; the adapter is master, memory/arbiter is slave.
interface cacheline_ufp_if #(
    parameter int LINE_W = 256
);
    logic [31:0]       addr;   // line address, low offset bits ignored
    logic              read;   // held until resp
    logic              write;  // held until resp
    logic [LINE_W-1:0] wdata;  // valid while write is high
    logic [LINE_W-1:0] rdata;  // valid while resp is high
    logic              resp;   // one-cycle completion pulse

    modport master (
        output addr, read, write, wdata,
        input  rdata, resp
    );

    modport slave (
        input  addr, read, write, wdata,
        output rdata, resp
    );
endinterface

interface cacheline_bmem_if #(
    parameter int BEAT_W = 64
);
    logic [31:0]       addr;   // line-aligned burst address
    logic              read;   // burst read request
    logic              write;  // write beat valid
    logic [BEAT_W-1:0] wdata;  // write beat data
    logic              ready;  // request or write beat accepted this cycle
    logic [31:0]       raddr;  // address tag of returning read beat
    logic [BEAT_W-1:0] rdata;  // read beat data
    logic              rvalid; // read beat valid

    modport master (
        output addr, read, write, wdata,
        input  ready, raddr, rdata, rvalid
    );

    modport slave (
        input  addr, read, write, wdata,
        output ready, raddr, rdata, rvalid
    );
endinterface

// File: rtl/cacheline_adapter.sv
// Purpose: serialise one whole-line cache read/write into four 64-bit memory beats and back.
// Latency: request picked up in IDLE drives memory next cycle; resp one cycle after the last beat.
// Backpressure: bmem.ready stalls the read request and holds each write beat; one transaction at a time.
//
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   ufp      : cacheline_ufp_if.slave  - line request from the cache, single-cycle resp
//   bmem     : cacheline_bmem_if.master - burst memory read request, write beats, tagged read beats
//   perf_rd_cnt, perf_wr_cnt : saturating completion counters, present only when
//                              CACHELINE_ADAPTER_PERF_EN is defined
module cacheline_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    cacheline_ufp_if.slave   ufp,
    cacheline_bmem_if.master bmem
`ifdef CACHELINE_ADAPTER_PERF_EN
    ,
    output logic [31:0]      perf_rd_cnt,
    output logic [31:0]      perf_wr_cnt
`endif
);

    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int OFF_W  = $clog2(LINE_W / 8);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_BEAT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] rline_q, rline_d;
    logic              op_wr_q, op_wr_d;

    logic              beat_match;
    logic [31:0]       aligned_addr;

    // Offset bits inside the line never reach memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ufp.addr[OFF_W-1:0];

    assign aligned_addr = {ufp.addr[31:OFF_W], {OFF_W{1'b0}}};

    // Read beats are tagged with their line address; anything else on the
    // return bus belongs to another requester or an abandoned burst.
    assign beat_match = bmem.rvalid && (bmem.raddr == addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            op_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            op_wr_q <= op_wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        op_wr_d = op_wr_q;

        case (state_q)
            IDLE: begin
                // Write takes priority if the cache ever raises both.
                if (ufp.write) begin
                    addr_d  = aligned_addr;
                    wline_d = ufp.wdata;
                    cnt_d   = '0;
                    op_wr_d = 1'b1;
                    state_d = WR_BEAT;
                end else if (ufp.read) begin
                    addr_d  = aligned_addr;
                    cnt_d   = '0;
                    op_wr_d = 1'b0;
                    state_d = RD_REQ;
                end
            end

            RD_REQ: begin
                if (bmem.ready) begin
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                if (beat_match) begin
                    rline_d[BEAT_W*int'(cnt_q) +: BEAT_W] = bmem.rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end

            WR_BEAT: begin
                if (bmem.ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every output is a register or a decode of registered state.
    assign bmem.read  = (state_q == RD_REQ);
    assign bmem.write = (state_q == WR_BEAT);
    assign bmem.addr  = addr_q;
    assign bmem.wdata = wline_q[BEAT_W*int'(cnt_q) +: BEAT_W];

    // The read line lives in its own register so a write does not disturb
    // the last assembled line.
    assign ufp.resp  = (state_q == DONE);
    assign ufp.rdata = rline_q;

`ifdef CACHELINE_ADAPTER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_cnt <= '0;
            perf_wr_cnt <= '0;
        end else if (state_q == DONE) begin
            if (op_wr_q) begin
                if (perf_wr_cnt != 32'hFFFF_FFFF) begin
                    perf_wr_cnt <= perf_wr_cnt + 32'd1;
                end
            end else begin
                if (perf_rd_cnt != 32'hFFFF_FFFF) begin
                    perf_rd_cnt <= perf_rd_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Purpose: randomized and directed checking of cacheline_adapter against a line-level memory model.
// Latency: scoreboard pops expected responses whenever ufp.resp is seen.
// Backpressure: memory model drives bmem.ready randomly or by directed pattern.
module tb_cacheline_adapter;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cacheline_ufp_if  #(.LINE_W(LINE_W)) ufp ();
    cacheline_bmem_if #(.BEAT_W(BEAT_W)) bmem ();

`ifdef CACHELINE_ADAPTER_PERF_EN
    logic [31:0] perf_rd_cnt;
    logic [31:0] perf_wr_cnt;
`endif

    cacheline_adapter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .ufp  (ufp),
        .bmem (bmem)
`ifdef CACHELINE_ADAPTER_PERF_EN
        ,
        .perf_rd_cnt (perf_rd_cnt),
        .perf_wr_cnt (perf_wr_cnt)
`endif
    );

    typedef struct {
        bit           is_rd;
        logic [255:0] line;
    } resp_t;

    typedef struct {
        bit          vld;
        bit          real_beat;
        logic [31:0] addr;
        logic [63:0] data;
    } beat_t;

    int checks   = 0;
    int failures = 0;

    resp_t       exp_resp_q[$];
    logic [63:0] exp_wbeat_q[$];
    beat_t       rsched_q[$];
    logic [63:0] wlog[$];
    logic [31:0] cur_addr = '0;

    // memory model knobs
    int          rdy_mode = 1;      // 0 random, 1 always ready, 2 stall write cycles 1 and 2
    int          lat_min = 0, lat_max = 0;
    int          gap_min = 0, gap_max = 0;
    int          stray_pct = 0;
    bit          wrong_inject = 1'b0;
    bit          fixed_en = 1'b0;
    logic [63:0] fixed_beats[4];

    // observation counters
    int n_resp = 0, n_read_cycles = 0, n_wr_accept = 0, n_rbeats_sent = 0;
    int wr_cyc_idx = 0, first_bus_cyc = -1;
    int exp_rd_done = 0, exp_wr_done = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_beat(input logic [31:0] a, input int i);
        return {a ^ 32'hC0DE_0000, a + 32'(i) * 32'h0101_0101 + 32'h1};
    endfunction

    // Expected line for a read of aligned address a: beat i lands in bits [64i +: 64].
    function automatic logic [255:0] ref_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 4; i++) l[64*i +: 64] = fixed_en ? fixed_beats[i] : mem_beat(a, i);
        return l;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom();
        return l;
    endfunction

    task automatic push_gap();
        beat_t g;
        g.vld = 1'b0; g.real_beat = 1'b0; g.addr = '0; g.data = '0;
        rsched_q.push_back(g);
    endtask

    // Schedule the four tagged beats of the current read after a random latency.
    task automatic sched_read();
        beat_t b;
        int lat = $urandom_range(lat_max, lat_min);
        for (int k = 0; k < lat; k++) push_gap();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                int g = $urandom_range(gap_max, gap_min);
                for (int k = 0; k < g; k++) push_gap();
            end
            if (wrong_inject && i == 2) begin
                b.vld = 1'b1; b.real_beat = 1'b0; b.addr = cur_addr + 32'h20;
                b.data = 64'hBAD0_BAD0_BAD0_BAD0;
                rsched_q.push_back(b);
            end
            b.vld = 1'b1; b.real_beat = 1'b1; b.addr = cur_addr; b.data = ref_line(cur_addr)[64*i +: 64];
            rsched_q.push_back(b);
        end
    endtask

    // Burst memory model: drives inputs on the falling edge, observes handshakes
    // that will complete on the following rising edge.
    initial begin : mem_model
        beat_t b;
        bit    drove;
        bmem.ready = 1'b0; bmem.rvalid = 1'b0; bmem.raddr = '0; bmem.rdata = '0;
        forever begin
            @(negedge clk);
            drove = 1'b0;
            if (rsched_q.size() > 0) begin
                b = rsched_q.pop_front();
                if (b.vld) begin
                    bmem.rvalid = 1'b1; bmem.raddr = b.addr; bmem.rdata = b.data;
                    drove = 1'b1;
                    if (b.real_beat) n_rbeats_sent++;
                end
            end
            if (!drove) begin
                if (stray_pct > 0 && $urandom_range(99) < stray_pct) begin
                    // odd tag: never equal to a line-aligned address
                    bmem.rvalid = 1'b1; bmem.raddr = $urandom() | 32'h1;
                    bmem.rdata = {$urandom(), $urandom()};
                end else begin
                    bmem.rvalid = 1'b0;
                end
            end
            case (rdy_mode)
                1:       bmem.ready = 1'b1;
                2:       bmem.ready = !(bmem.write === 1'b1 && (wr_cyc_idx == 1 || wr_cyc_idx == 2));
                default: bmem.ready = ($urandom_range(99) < 60);
            endcase
            if (bmem.write === 1'b1) begin
                wlog.push_back(bmem.wdata);
                wr_cyc_idx++;
            end else begin
                wr_cyc_idx = 0;
            end
            if ((bmem.read === 1'b1 || bmem.write === 1'b1) && first_bus_cyc < 0) first_bus_cyc = cyc;
            if (bmem.read === 1'b1) n_read_cycles++;
            if (bmem.read === 1'b1 && bmem.ready) begin
                check("rd_req_addr", bmem.addr, cur_addr);
                sched_read();
            end
            if (bmem.write === 1'b1 && bmem.ready) begin
                check("wr_beat_addr", bmem.addr, cur_addr);
                if (exp_wbeat_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wr_extra_beat: got beat %0h expected none", bmem.wdata);
                end else begin
                    check("wr_beat_data", bmem.wdata, exp_wbeat_q.pop_front());
                end
                n_wr_accept++;
            end
        end
    end

    // Response monitor / scoreboard.
    initial begin : resp_monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (ufp.resp === 1'b1) begin
                n_resp++;
                if (exp_resp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_resp: got ufp_resp=1 expected no response pending");
                end else begin
                    e = exp_resp_q.pop_front();
                    if (e.is_rd) begin
                        check("rd_line", ufp.rdata, e.line);
                        exp_rd_done++;
                    end else begin
                        check("wr_beats_left_at_resp", 256'(exp_wbeat_q.size()), 256'd0);
                        exp_wr_done++;
                    end
                end
            end
        end
    end

    // One cache transaction: pushes expectations, holds the request until resp.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] wd,
                          output int lat_out, output int req_out);
        resp_t e;
        int    t0;
        bit    seen;
        @(negedge clk);
        cur_addr = {a[31:5], 5'b0};
        e.is_rd = !wr;
        e.line  = '0;
        if (wr) begin
            for (int i = 0; i < 4; i++) exp_wbeat_q.push_back(wd[64*i +: 64]);
        end else begin
            e.line = ref_line(cur_addr);
        end
        exp_resp_q.push_back(e);
        ufp.addr = a; ufp.read = rd; ufp.write = wr; ufp.wdata = wr ? wd : '0;
        t0 = cyc; first_bus_cyc = -1; seen = 1'b0; lat_out = -1;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (ufp.resp === 1'b1) begin
                seen = 1'b1;
                lat_out = cyc - t0;
            end
        end
        req_out = first_bus_cyc - t0;
        ufp.read = 1'b0; ufp.write = 1'b0; ufp.wdata = '0;
        if (!seen) begin
            checks++; failures++;
            $display("FAIL txn_timeout: got no ufp_resp in 400 cycles expected one for addr %0h", a);
            exp_resp_q.delete();
            exp_wbeat_q.delete();
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          lat, req, n0, wa, nrc, base;
        logic [63:0] wa_b, wb_b, wc_b, wd_b;
        logic [63:0] seq[6];
        logic [255:0] wline, last_rd;
        beat_t       sb;
        bit          got2;

        rst = 1'b1;
        ufp.addr = '0; ufp.read = 1'b0; ufp.write = 1'b0; ufp.wdata = '0;
        repeat (3) @(negedge clk);

        check("rst_ufp_resp",   ufp.resp,   1'b0);
        check("rst_bmem_read",  bmem.read,  1'b0);
        check("rst_bmem_write", bmem.write, 1'b0);
        check("rst_bmem_addr",  bmem.addr,  32'h0);
        check("rst_bmem_wdata", bmem.wdata, 64'h0);
        check("rst_ufp_rdata",  ufp.rdata,  256'h0);
`ifdef CACHELINE_ADAPTER_PERF_EN
        check("rst_perf_rd", perf_rd_cnt, 32'h0);
        check("rst_perf_wr", perf_wr_cnt, 32'h0);
`endif
        rst = 1'b0;

        // Ideal read: ready immediately, one-cycle memory latency, beats back-to-back.
        rdy_mode = 1; lat_min = 1; lat_max = 1; gap_min = 0; gap_max = 0; stray_pct = 0;
        fixed_en = 1'b1;
        fixed_beats[0] = 64'h1111_1111_1111_1111;
        fixed_beats[1] = 64'h2222_2222_2222_2222;
        fixed_beats[2] = 64'h3333_3333_3333_3333;
        fixed_beats[3] = 64'h4444_4444_4444_4444;
        n0 = n_resp;
        do_txn(1'b1, 1'b0, 32'h0000_1234, '0, lat, req);
        check("rd_ideal_req_cycle", req, 1);
        check("rd_ideal_resp_latency", lat, 7);
        @(negedge clk);
        check("rd_ideal_resp_count", n_resp - n0, 1);
        last_rd = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        check("rd_ideal_rdata_hold", ufp.rdata, last_rd);
        fixed_en = 1'b0;

        // Write with ready low on the 2nd and 3rd write cycles.
        rdy_mode = 2;
        wa_b = 64'hAAAA_0000_AAAA_0001; wb_b = 64'hBBBB_0000_BBBB_0002;
        wc_b = 64'hCCCC_0000_CCCC_0003; wd_b = 64'hDDDD_0000_DDDD_0004;
        wline = {wd_b, wc_b, wb_b, wa_b};
        wlog.delete(); wa = n_wr_accept; n0 = n_resp;
        do_txn(1'b0, 1'b1, 32'h0000_0080, wline, lat, req);
        check("wr_req_cycle", req, 1);
        @(negedge clk);
        seq[0] = wa_b; seq[1] = wb_b; seq[2] = wb_b; seq[3] = wb_b; seq[4] = wc_b; seq[5] = wd_b;
        check("wr_stall_cycles", wlog.size(), 6);
        for (int i = 0; i < 6 && i < wlog.size(); i++) check($sformatf("wr_stall_seq%0d", i), wlog[i], seq[i]);
        check("wr_stall_accepted", n_wr_accept - wa, 4);
        check("wr_stall_resp_count", n_resp - n0, 1);
        check("rdata_held_over_write", ufp.rdata, last_rd);

        // Read and write together: only the write burst happens.
        rdy_mode = 0;
        nrc = n_read_cycles; wa = n_wr_accept;
        do_txn(1'b1, 1'b1, 32'h0000_4444, rand_line(), lat, req);
        @(negedge clk);
        check("rdwr_no_bmem_read", n_read_cycles - nrc, 0);
        check("rdwr_write_beats", n_wr_accept - wa, 4);

        // Stray beat in IDLE carrying the next read's own tag, then wrong tags mid-burst.
        sb.vld = 1'b1; sb.real_beat = 1'b0; sb.addr = 32'h0000_2000; sb.data = 64'hDEAD_BEEF_DEAD_BEEF;
        rsched_q.push_back(sb);
        rsched_q.push_back(sb);
        repeat (4) @(negedge clk);
        wrong_inject = 1'b1; stray_pct = 50; lat_min = 0; lat_max = 2; gap_min = 0; gap_max = 2;
        n0 = n_resp;
        do_txn(1'b1, 1'b0, 32'h0000_2010, '0, lat, req);
        @(negedge clk);
        check("stray_resp_count", n_resp - n0, 1);
        wrong_inject = 1'b0; stray_pct = 0;

        // Reset in the middle of a read; the remaining beats arrive after reset.
        rdy_mode = 1; lat_min = 0; lat_max = 0; gap_min = 2; gap_max = 2;
        @(negedge clk);
        cur_addr = 32'h0000_3000;
        base = n_rbeats_sent; n0 = n_resp;
        ufp.addr = 32'h0000_3000; ufp.read = 1'b1;
        got2 = 1'b0;
        for (int k = 0; k < 100 && !got2; k++) begin
            @(negedge clk);
            if (n_rbeats_sent - base >= 2) got2 = 1'b1;
        end
        check("midrd_two_beats_sent", got2, 1'b1);
        @(negedge clk);
        rst = 1'b1; ufp.read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_rd_done = 0; exp_wr_done = 0;
        repeat (15) @(negedge clk);
        check("midrd_no_resp", n_resp - n0, 0);
        check("midrd_idle_read", bmem.read, 1'b0);
        check("midrd_idle_write", bmem.write, 1'b0);
        check("midrd_beats_drained", n_rbeats_sent - base, 4);
        n0 = n_resp;
        do_txn(1'b1, 1'b0, 32'h0000_5008, '0, lat, req);
        @(negedge clk);
        check("after_rst_read_resp", n_resp - n0, 1);

        // Randomized traffic.
        rdy_mode = 0; lat_min = 0; lat_max = 3; gap_min = 0; gap_max = 2; stray_pct = 20;
        for (int t = 0; t < 40; t++) begin
            int op = $urandom_range(9);
            logic [31:0] a = $urandom();
            if (op < 5)      do_txn(1'b1, 1'b0, a, '0, lat, req);
            else if (op < 9) do_txn(1'b0, 1'b1, a, rand_line(), lat, req);
            else             do_txn(1'b1, 1'b1, a, rand_line(), lat, req);
        end
        repeat (3) @(negedge clk);

`ifdef CACHELINE_ADAPTER_PERF_EN
        check("perf_rd_cnt", perf_rd_cnt, 32'(exp_rd_done));
        check("perf_wr_cnt", perf_wr_cnt, 32'(exp_wr_done));
`endif
        check("resp_queue_drained", exp_resp_q.size(), 0);
        check("wbeat_queue_drained", exp_wbeat_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
